jk_valve_bank: RTL and testbench

- Parametrised bank of WIDTH JK storage cells for valve-drive control in the irrigation controller.
- Successor of the single JK flip-flop; adds the following:
  - per-channel enable
  - synchronous global clear and parallel load
  - registered rise/fall event pulses
  - per-channel minimum-hold timer that blocks JK-driven changes for HOLD_CYCLES edges after any change (valve chatter protection)
- Sits between the irrigation control FSM (drives j/k/en) and the valve output drivers / event logger (consume q, rise, fall).

---
 rtl/jk_valve_pkg.sv | 19 +
 rtl/jk_valve_cell.sv | 109 ++++++++++
 rtl/jk_valve_bank.sv | 55 +++++
 tb/tb_jk_valve_bank.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/jk_valve_pkg.sv
// jk_valve_pkg: shared constants and helpers for the JK valve bank.
//   JK_* : 2-bit {j,k} operation codes
//   calc_tw : width of the per-channel hold timer for a given hold length
package jk_valve_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Timer must hold values 0..hold; keep at least one bit so the type stays legal.
  function automatic int unsigned calc_tw(input int unsigned hold);
    if (hold == 0) begin
      return 1;
    end
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/jk_valve_cell.sv
// jk_valve_cell: one valve channel -- JK state bit, minimum-hold timer and
// registered rise/fall event pulses.
//   i_clk, i_reset      : clock, asynchronous active-low reset
//   i_en, i_j, i_k      : JK request for this channel
//   i_clr, i_load, i_d  : global clear / parallel load (scalars for this channel)
//   o_q                 : channel state
//   o_rise, o_fall      : one-cycle pulses on 0->1 / 1->0 of o_q
//   o_busy              : hold timer nonzero (JK requests ignored)
module jk_valve_cell
  import jk_valve_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 3,
  parameter int unsigned TW          = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_j,
  input  logic i_k,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  logic r_q;
  logic r_rise;
  logic r_fall;
  logic w_jk_q;
  logic w_nq;
  logic w_timer_zero;

  always_comb begin
    w_jk_q = r_q;
    unique case ({i_j, i_k})
      JK_HOLD: w_jk_q = r_q;
      JK_RST:  w_jk_q = 1'b0;
      JK_SET:  w_jk_q = 1'b1;
      JK_TGL:  w_jk_q = ~r_q;
      default: w_jk_q = r_q;
    endcase
  end

  // clr > load > JK; JK only while the channel is not holding.
  always_comb begin
    w_nq = r_q;
    if (i_clr) begin
      w_nq = 1'b0;
    end else if (i_load) begin
      w_nq = i_d;
    end else if (i_en && w_timer_zero) begin
      w_nq = w_jk_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_q    <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_q    <= w_nq;
      r_rise <= ~r_q & w_nq;
      r_fall <= r_q & ~w_nq;
    end
  end

  generate
    if (HOLD_CYCLES > 0) begin : g_hold
      localparam logic [TW-1:0] HoldLoad = TW'(HOLD_CYCLES);
      logic [TW-1:0] r_timer;
      logic [TW-1:0] w_timer_nxt;

      // Clear is an emergency shut-off and never leaves the channel holding.
      always_comb begin
        w_timer_nxt = r_timer;
        if (i_clr) begin
          w_timer_nxt = '0;
        end else if (w_nq != r_q) begin
          w_timer_nxt = HoldLoad;
        end else if (r_timer != '0) begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          r_timer <= '0;
        end else begin
          r_timer <= w_timer_nxt;
        end
      end

      assign w_timer_zero = (r_timer == '0);
      assign o_busy       = ~w_timer_zero;
    end else begin : g_nohold
      assign w_timer_zero = 1'b1;
      assign o_busy       = 1'b0;
    end
  endgenerate

  assign o_q    = r_q;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/jk_valve_bank.sv
// jk_valve_bank: WIDTH independent JK valve channels with chatter protection.
//   i_clk, i_reset        : clock, asynchronous active-low reset
//   i_en, i_j, i_k        : per-channel JK enable and inputs
//   i_clr, i_load, i_d    : global synchronous clear / parallel load and data
//   o_q, o_qn             : channel state and its complement
//   o_rise, o_fall        : registered per-channel edge event pulses
//   o_busy                : per-channel hold timer active
module jk_valve_bank
  import jk_valve_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_en,
  input  logic [WIDTH-1:0] i_j,
  input  logic [WIDTH-1:0] i_k,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qn,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic [WIDTH-1:0] o_busy
);

  localparam int unsigned TW = calc_tw(HOLD_CYCLES);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_valve_cell #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .TW          (TW)
      ) u_cell (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_en[gi]),
        .i_j     (i_j[gi]),
        .i_k     (i_k[gi]),
        .i_clr   (i_clr),
        .i_load  (i_load),
        .i_d     (i_d[gi]),
        .o_q     (o_q[gi]),
        .o_rise  (o_rise[gi]),
        .o_fall  (o_fall[gi]),
        .o_busy  (o_busy[gi])
      );
    end
  endgenerate

  assign o_qn = ~o_q;

endmodule

// File: tb/tb_jk_valve_bank.sv
module tb_jk_valve_bank;

  logic       clk;
  logic       rst;
  logic [3:0] en, j, k, d;
  logic       clr, load;
  logic [3:0] q, qn, rise, fall, busy;

  logic [3:0] h_en, h_j, h_k, h_d;
  logic       h_clr, h_load;
  logic [3:0] h_q, h_qn, h_rise, h_fall, h_busy;

  int n_checks = 0;
  int n_errors = 0;

  jk_valve_bank #(.WIDTH(4), .HOLD_CYCLES(3)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_j(j), .i_k(k), .i_clr(clr),
    .i_load(load), .i_d(d), .o_q(q), .o_qn(qn), .o_rise(rise), .o_fall(fall),
    .o_busy(busy)
  );

  jk_valve_bank #(.WIDTH(4), .HOLD_CYCLES(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_en(h_en), .i_j(h_j), .i_k(h_k), .i_clr(h_clr),
    .i_load(h_load), .i_d(h_d), .o_q(h_q), .o_qn(h_qn), .o_rise(h_rise),
    .o_fall(h_fall), .o_busy(h_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] en, j, k;
    logic       clr, load;
    logic [3:0] d;
    logic [3:0] eq, er, ef, eb;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eq, input logic [3:0] er,
                           input logic [3:0] ef, input logic [3:0] eb);
    check({tag, " q"}, q, eq);
    check({tag, " qn"}, qn, ~eq);
    check({tag, " rise"}, rise, er);
    check({tag, " fall"}, fall, ef);
    check({tag, " busy"}, busy, eb);
  endtask

  task automatic drive(input logic [3:0] e, input logic [3:0] jj, input logic [3:0] kk,
                       input logic c, input logic l, input logic [3:0] dd);
    en = e; j = jj; k = kk; clr = c; load = l; d = dd;
  endtask

  initial begin
    logic [3:0] mq, mnq, jk_q;
    logic       tq;
    int         ph;

    rst = 1'b0;
    drive(4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    h_en = '0; h_j = '0; h_k = '0; h_d = '0; h_clr = 1'b0; h_load = 1'b0;

    //        en       j        k      clr   load   d        q        rise     fall     busy
    vecs[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1]  = '{4'b0101, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0101, 4'b0101, 4'b0000, 4'b0101};
    vecs[2]  = '{4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1010, 4'b0000, 4'b1111};
    vecs[3]  = '{4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1111};
    vecs[4]  = '{4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b1010};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b1010, 4'b0000, 4'b0101, 4'b0101};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b1111};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b1111};
    vecs[8]  = '{4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1010, 4'b0000};
    vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0110, 4'b0110, 4'b0110, 4'b0000, 4'b0110};
    vecs[10] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0110, 4'b0111};
    vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0111};
    vecs[12] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0111};
    vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vecs[14] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
    vecs[15] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    vecs[16] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    vecs[17] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    // Reset state
    #12;
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    check("reset h0 q", h_q, 4'b0000);
    @(negedge clk);
    rst = 1'b1;

    // Table: enable gating, hold blocking, priority, load during hold
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].en, vecs[i].j, vecs[i].k, vecs[i].clr, vecs[i].load, vecs[i].d);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].er, vecs[i].ef, vecs[i].eb);
    end

    // Toggle on ch0: changes every HOLD_CYCLES+1 = 4 edges
    drive(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'b0000);
    for (int e = 0; e < 10; e++) begin
      @(posedge clk);
      #1;
      tq = ((e / 4) % 2) == 0;
      check_all($sformatf("tgl%0d", e), {3'b000, tq},
                {3'b000, (e % 4 == 0) && tq}, {3'b000, (e % 4 == 0) && !tq},
                {3'b000, (e % 4) != 3});
    end

    // Async reset mid-hold: q=1011, timers running
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b1011);
    @(posedge clk);
    #1;
    check_all("preload", 4'b1011, 4'b1010, 4'b0000, 4'b1011);
    drive(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
    #2;
    rst = 1'b0;
    #1;
    check_all("async rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    check_all("rst held", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drive(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 4'b0000);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("post rst", 4'b1111, 4'b1111, 4'b0000, 4'b1111);

    // HOLD_CYCLES=0 instance against a plain JK reference
    h_clr = 1'b1;
    @(posedge clk);
    #1;
    check("h0 clr q", h_q, 4'b0000);
    mq = 4'b0000;
    h_clr = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      h_en   = 4'($urandom);
      h_j    = 4'($urandom);
      h_k    = 4'($urandom);
      h_d    = 4'($urandom);
      h_load = ($urandom_range(0, 31) == 0);
      h_clr  = ($urandom_range(0, 63) == 0);
      for (int b = 0; b < 4; b++) begin
        ph = {h_j[b], h_k[b]};
        case (ph)
          1:       jk_q[b] = 1'b0;
          2:       jk_q[b] = 1'b1;
          3:       jk_q[b] = ~mq[b];
          default: jk_q[b] = mq[b];
        endcase
        mnq[b] = h_en[b] ? jk_q[b] : mq[b];
      end
      if (h_clr) mnq = 4'b0000;
      else if (h_load) mnq = h_d;
      @(posedge clk);
      #1;
      n_checks++;
      if ({h_q, h_qn, h_rise, h_fall, h_busy} !== {mnq, ~mnq, ~mq & mnq, mq & ~mnq, 4'b0000}) begin
        n_errors++;
        $display("FAIL h0 cycle %0d: got q=%b rise=%b fall=%b busy=%b expected q=%b rise=%b fall=%b busy=0000",
                 c, h_q, h_rise, h_fall, h_busy, mnq, ~mq & mnq, mq & ~mnq);
      end
      mq = mnq;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
